// File: rtl/cam_test_pkg.sv
// cam_test_pkg: shared encodings and default timing constants for the
// board-bring-up controller user-input front end.
package cam_test_pkg;

    // Handshake FSM state encodings.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACK_LO = 2'd2
    } state_e;

    // Default timing in 1 us ticks.
    localparam int DEBOUNCE_US_DEF      = 20000;
    localparam int REPEAT_DELAY_US_DEF  = 500000;
    localparam int REPEAT_PERIOD_US_DEF = 250000;

    // Width of the saturating dropped-press counter.
    localparam int DROP_W = 8;

    // Saturating increment for the dropped-press counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        logic [DROP_W-1:0] r;
        if (v == {DROP_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + DROP_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_1us.sv
// debounce_1us: 2-flop synchroniser, stability counter and debounced level
// for one active-low key. rise_o pulses in the cycle whose clock edge
// turns the debounced level from released to pressed.
module debounce_1us
    import cam_test_pkg::*;
#(
    parameter int DEBOUNCE_US = DEBOUNCE_US_DEF
) (
    input  logic clk_1us,
    input  logic reset,
    input  logic key_n_i,
    output logic key_state_o,
    output logic rise_o
);

    localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_US - 1);

    logic [1:0]  sync_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        state_q;
    logic        state_d;
    logic        differ_s;
    logic        done_s;

    // Synchronise the key as an active-high "pressed" level.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ~key_n_i};
        end
    end

    // Count consecutive cycles the synchronised key disagrees with the accepted level.
    always_comb begin
        differ_s = sync_q[1] ^ state_q;
        done_s   = differ_s && (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        state_d  = state_q;
        if (!differ_s) begin
            cnt_d = 32'd0;
        end else if (done_s) begin
            cnt_d   = 32'd0;
            state_d = ~state_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter and accepted level registers.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 32'd0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign key_state_o = state_q;
    assign rise_o      = done_s && sync_q[1];

endmodule

// File: rtl/reg_read_trigger.sv
// reg_read_trigger: debounced "read register" key that issues one 4-phase
// req/ack request (with a latched register address) per accepted press.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat press events.
module reg_read_trigger
    import cam_test_pkg::*;
#(
    parameter int DEBOUNCE_US      = DEBOUNCE_US_DEF,
    parameter int REPEAT_DELAY_US  = REPEAT_DELAY_US_DEF,
    parameter int REPEAT_PERIOD_US = REPEAT_PERIOD_US_DEF,
    parameter int ADDR_W           = 8
) (
    input  logic              clk_1us,
    input  logic              reset,
    input  logic              key_n,
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic              ack,
    output logic              req,
    output logic [ADDR_W-1:0] req_addr,
    output logic              key_state,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [ADDR_W-1:0] addr_meta_q;
    logic [ADDR_W-1:0] addr_sync_q;
    logic [1:0]        ack_sync_q;
    logic              ack_s;
    logic              key_state_s;
    logic              rise_s;
    logic              event_s;
    logic              launch_s;

    state_e            state_q;
    state_e            state_d;
    logic              req_q;
    logic              req_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [ADDR_W-1:0] req_addr_d;
    logic              busy_q;
    logic              busy_d;
    logic              pending_q;
    logic              pending_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    debounce_1us #(
        .DEBOUNCE_US (DEBOUNCE_US)
    ) u_key_debounce (
        .clk_1us     (clk_1us),
        .reset       (reset),
        .key_n_i     (key_n),
        .key_state_o (key_state_s),
        .rise_o      (rise_s)
    );

    // Two-flop synchronisers for the address switches and the acknowledge.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            addr_meta_q <= {ADDR_W{1'b0}};
            addr_sync_q <= {ADDR_W{1'b0}};
            ack_sync_q  <= 2'b00;
        end else begin
            addr_meta_q <= addr_sw;
            addr_sync_q <= addr_meta_q;
            ack_sync_q  <= {ack_sync_q[0], ack};
        end
    end

    assign ack_s = ack_sync_q[1];

`ifdef AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q;
    logic [31:0] rpt_cnt_d;
    logic        rpt_first_q;
    logic        rpt_first_d;
    logic [31:0] rpt_limit_s;
    logic        rpt_fire_s;

    // Repeat timer: first event after the delay, then one per period while held.
    always_comb begin
        rpt_limit_s = rpt_first_q ? 32'(REPEAT_DELAY_US - 1) : 32'(REPEAT_PERIOD_US - 1);
        rpt_fire_s  = 1'b0;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        if (!key_state_s) begin
            rpt_cnt_d   = 32'd0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == rpt_limit_s) begin
            rpt_fire_s  = 1'b1;
            rpt_cnt_d   = 32'd0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 32'd1;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            rpt_cnt_q   <= 32'd0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign event_s = rise_s | rpt_fire_s;
`else
    // Repeat timing is only consumed when the auto-repeat generator is built.
    if ((REPEAT_DELAY_US < 1) || (REPEAT_PERIOD_US < 1)) begin : g_repeat_unused
    end

    assign event_s = rise_s;
`endif

    // FSM state register and registered outputs/bookkeeping.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            req_addr_q <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            drop_q     <= {DROP_W{1'b0}};
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic for the 4-phase handshake.
    always_comb begin
        state_d  = state_q;
        launch_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    launch_s = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    state_d = S_ACK_LO;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_ACK_LO: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACK_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values: req follows S_REQ, address latched only at launch.
    always_comb begin
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        if (launch_s) begin
            req_addr_d = addr_sync_q;
        end else begin
            req_addr_d = req_addr_q;
        end
    end

    // One-deep pending flag; a launch in the same cycle frees the slot for the new event.
    always_comb begin
        pending_d = pending_q;
        drop_d    = drop_q;
        if (event_s) begin
            pending_d = 1'b1;
            if (pending_q && !launch_s) begin
                drop_d = sat_inc(drop_q);
            end else begin
                drop_d = drop_q;
            end
        end else if (launch_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    assign req       = req_q;
    assign req_addr  = req_addr_q;
    assign key_state = key_state_s;
    assign busy      = busy_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_reg_read_trigger.sv
// tb_reg_read_trigger: scenario tasks with a request scoreboard (expected
// request cycle/address pushed at stimulus time, popped against observed
// req rising edges).
module tb_reg_read_trigger;

    logic       clk_1us = 1'b0;
    logic       reset   = 1'b0;
    logic       key_n   = 1'b1;
    logic [7:0] addr_sw = 8'h00;
    logic       ack     = 1'b0;
    logic       req;
    logic [7:0] req_addr;
    logic       key_state;
    logic       busy;
    logic [7:0] drop_cnt;

    reg_read_trigger #(
        .DEBOUNCE_US      (10),
        .REPEAT_DELAY_US  (50),
        .REPEAT_PERIOD_US (20),
        .ADDR_W           (8)
    ) dut (
        .clk_1us   (clk_1us),
        .reset     (reset),
        .key_n     (key_n),
        .addr_sw   (addr_sw),
        .ack       (ack),
        .req       (req),
        .req_addr  (req_addr),
        .key_state (key_state),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_1us = ~clk_1us;

    int cyc = 0;
    always @(posedge clk_1us) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e;
    ev_t  o;
    logic req_prev = 1'b0;

    // Record every req rising edge with its cycle and address.
    always @(negedge clk_1us) begin
        ev_t m;
        if (req === 1'b1 && req_prev !== 1'b1) begin
            m.cyc  = cyc;
            m.addr = req_addr;
            obs_q.push_back(m);
        end
        req_prev = req;
    end

    task automatic tick();
        @(posedge clk_1us);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input int c, input logic [7:0] a);
        ev_t x;
        x.cyc  = c;
        x.addr = a;
        exp_q.push_back(x);
    endtask

    task automatic wait_req(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (req === lvl) ok = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake(input int dly, output bit ok);
        bit ok1, ok2, ok3;
        wait_req(1'b1, 40, ok1);
        ticks(dly);
        ack = 1'b1;
        wait_req(1'b0, 20, ok2);
        ticks(dly);
        ack = 1'b0;
        wait_idle(20, ok3);
        ok = ok1 && ok2 && ok3;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(3);
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h want 00", req_addr); end
        checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL reset_key: got %b want 0", key_state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop: got %h want 00", drop_cnt); end
        reset = 1'b1;
        ticks(3);
    endtask

    task automatic test_clean_press();
        int t, a, b, r;
        bit ok;
        addr_sw = 8'h42;
        ticks(4);
        t = cyc;
        key_n = 1'b0;
        push_exp(t + 13, 8'h42);
        wait_req(1'b1, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL clean_req_rise: req=%b after 40 cycles, want 1", req); end
        ticks(5);
        ack = 1'b1;
        a = cyc;
        wait_req(1'b0, 20, ok);
        checks++; if (!ok || (cyc - a) != 3) begin failures++; $display("FAIL clean_req_fall: fell %0d cycles after ack, want 3", cyc - a); end
        ticks(5);
        ack = 1'b0;
        b = cyc;
        wait_idle(20, ok);
        checks++; if (!ok || (cyc - b) != 3) begin failures++; $display("FAIL clean_idle: idle %0d cycles after ack low, want 3", cyc - b); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL clean_drop: got %h want 00", drop_cnt); end
        checks++; if (key_state !== 1'b1) begin failures++; $display("FAIL clean_key_held: got %b want 1", key_state); end
        key_n = 1'b1;
        r = cyc;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_state === 1'b0) break;
        end
        checks++; if (key_state !== 1'b0 || (cyc - r) != 12) begin failures++; $display("FAIL clean_release: key_state=%b after %0d cycles, want 0 after 12", key_state, cyc - r); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL clean_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL clean_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
    endtask

    task automatic test_bounce();
        int t;
        bit ok;
        addr_sw = 8'h5A;
        ticks(2);
        for (int i = 0; i < 10; i++) begin
            key_n = ~key_n;
            ticks(4);
        end
        key_n = 1'b0;
        t = cyc;
        push_exp(t + 13, 8'h5A);
        handshake(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bounce_handshake: did not complete, busy=%b req=%b", busy, req); end
        key_n = 1'b1;
        ticks(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL bounce_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL bounce_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_extra: %0d extra requests, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_addr_hold();
        int t;
        bit ok;
        addr_sw = 8'h42;
        ticks(4);
        t = cyc;
        key_n = 1'b0;
        push_exp(t + 13, 8'h42);
        wait_req(1'b1, 40, ok);
        addr_sw = 8'h10;
        ticks(8);
        checks++; if (req !== 1'b1 || req_addr !== 8'h42) begin failures++; $display("FAIL addr_hold_req: req=%b addr=%h, want 1/42", req, req_addr); end
        handshake(2, ok);
        checks++; if (!ok || req_addr !== 8'h42) begin failures++; $display("FAIL addr_hold_after: ok=%b addr=%h, want 1/42", ok, req_addr); end
        key_n = 1'b1;
        ticks(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL addr_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL addr_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
    endtask

    task automatic test_drop();
        int b;
        bit ok;
        ack = 1'b0;
        addr_sw = 8'h21;
        ticks(3);
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b0;
            if (i == 0) push_exp(cyc + 13, 8'h21);
            ticks(15);
            key_n = 1'b1;
            ticks(15);
        end
        checks++; if (drop_cnt !== 8'h01) begin failures++; $display("FAIL drop_count: got %h want 01", drop_cnt); end
        checks++; if (req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL drop_req_held: req=%b busy=%b, want 1/1", req, busy); end
        addr_sw = 8'h33;
        ticks(3);
        ack = 1'b1;
        wait_req(1'b0, 20, ok);
        ticks(2);
        ack = 1'b0;
        b = cyc;
        push_exp(b + 4, 8'h33);
        wait_req(1'b1, 20, ok);
        checks++; if (!ok || (cyc - b) != 4) begin failures++; $display("FAIL drop_second_req: req=%b at %0d cycles after ack low, want 1 at 4", req, cyc - b); end
        handshake(1, ok);
        checks++; if (!ok || drop_cnt !== 8'h01 || busy !== 1'b0) begin failures++; $display("FAIL drop_final: ok=%b drop=%h busy=%b, want 1/01/0", ok, drop_cnt, busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL drop_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL drop_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL drop_extra: %0d extra requests, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok;
        addr_sw = 8'h77;
        ticks(4);
        t = cyc;
        key_n = 1'b0;
        push_exp(t + 13, 8'h77);
        wait_req(1'b1, 40, ok);
        ticks(2);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %b want 0", req); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL rstmid_addr: got %h want 00", req_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL rstmid_drop: got %h want 00", drop_cnt); end
        key_n = 1'b1;
        ticks(3);
        reset = 1'b1;
        ticks(5);
        checks++; if (busy !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy=%b req=%b, want 0/0", busy, req); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL rstmid_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL rstmid_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int t;
        addr_sw = 8'h3C;
        ticks(4);
        t = cyc;
        key_n = 1'b0;
        push_exp(t + 13, 8'h3C);
        push_exp(t + 63, 8'h3C);
        push_exp(t + 83, 8'h3C);
        push_exp(t + 103, 8'h3C);
        for (int i = 0; i < 140; i++) begin
            tick();
            ack = req;
            if (cyc == t + 107) key_n = 1'b1;
        end
        ack = 1'b0;
        ticks(5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL repeat_sb: no request, want cycle %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.addr !== e.addr) begin failures++; $display("FAIL repeat_sb: got cycle %0d addr %h, want cycle %0d addr %h", o.cyc, o.addr, e.cyc, e.addr); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL repeat_extra: %0d extra requests, want 0", obs_q.size()); obs_q.delete(); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_addr_hold();
        test_drop();
        test_reset_mid();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
